// File: rtl/axi_stream_sequence_source.sv
// ---------------------------------------------------------------------------
// axi_stream_sequence_source
//
// Command-driven stream transmitter for a valid/ready pipeline. One command
// (start, stride, count) is taken on the cmd_* handshake. The block then
// emits count beats start, start+stride, start+2*stride, ... on the master
// stream port and pulses done for one cycle when the command ends. An abort
// request ends the running command at the next beat boundary.
//
// Parameters
//   WIDTH        data / start / stride width in bits
//   COUNT_WIDTH  beat-count width (max 2^COUNT_WIDTH-1 beats per command)
//
// Ports
//   clk           rising-edge clock
//   reset         synchronous, active-high reset
//   cmd_valid     command present
//   cmd_ready     block can accept a command (idle and not in reset)
//   cmd_start     first beat value
//   cmd_stride    unsigned increment per beat
//   cmd_count     number of beats, zero allowed
//   abort         stop the running command at the next beat boundary
//   m_data        stream data
//   m_valid       stream data valid
//   m_ready       downstream accepts
//   m_last        final beat of the command
//   done          one-cycle completion pulse
//   done_aborted  qualifies done: command ended by abort
//   done_count    beats transferred, valid while done is high
// ---------------------------------------------------------------------------
module axi_stream_sequence_source #(
  parameter int WIDTH       = 32,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [WIDTH-1:0]       cmd_start,
  input  logic [WIDTH-1:0]       cmd_stride,
  input  logic [COUNT_WIDTH-1:0] cmd_count,
  input  logic                   abort,
  output logic [WIDTH-1:0]       m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   m_last,
  output logic                   done,
  output logic                   done_aborted,
  output logic [COUNT_WIDTH-1:0] done_count
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } stateT;

  stateT                  r_state;
  logic [WIDTH-1:0]       r_cur;
  logic [WIDTH-1:0]       r_stride;
  logic [COUNT_WIDTH-1:0] r_remaining;
  logic [COUNT_WIDTH-1:0] r_sent;
  logic                   r_abortPending;
  logic                   r_cmdReady;
  logic                   r_mValid;
  logic                   r_mLast;
  logic                   r_done;
  logic                   r_doneAborted;
  logic [COUNT_WIDTH-1:0] r_doneCount;

  logic                   w_beatXfer;
  logic                   w_cmdXfer;
  logic                   w_abortNow;
  logic [COUNT_WIDTH-1:0] w_remainingNext;
  logic [COUNT_WIDTH-1:0] w_sentNext;

  assign w_beatXfer      = r_mValid && m_ready;
  assign w_cmdXfer       = cmd_valid && r_cmdReady;
  // An abort arriving on the same edge as a beat transfer counts immediately.
  assign w_abortNow      = abort || r_abortPending;
  assign w_remainingNext = r_remaining - COUNT_WIDTH'(1);
  assign w_sentNext      = r_sent + COUNT_WIDTH'(1);

  // cmd_ready is the registered idle flag, forced low while reset is held.
  assign cmd_ready    = r_cmdReady && !reset;
  assign m_data       = r_cur;
  assign m_valid      = r_mValid;
  assign m_last       = r_mLast;
  assign done         = r_done;
  assign done_aborted = r_doneAborted;
  assign done_count   = r_doneCount;

  // Single sequencer: IDLE waits for a command, RUN walks the arithmetic
  // sequence one beat per transfer, DONE holds the completion pulse for one
  // cycle and forces a bubble before the next command can be taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= IDLE;
      r_cur          <= '0;
      r_stride       <= '0;
      r_remaining    <= '0;
      r_sent         <= '0;
      r_abortPending <= 1'b0;
      r_cmdReady     <= 1'b1;
      r_mValid       <= 1'b0;
      r_mLast        <= 1'b0;
      r_done         <= 1'b0;
      r_doneAborted  <= 1'b0;
      r_doneCount    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_cmdXfer) begin
            r_cur          <= cmd_start;
            r_stride       <= cmd_stride;
            r_remaining    <= cmd_count;
            r_sent         <= '0;
            r_abortPending <= 1'b0;
            r_cmdReady     <= 1'b0;
            if (cmd_count == '0) begin
              // Empty command: straight to completion, no beat emitted.
              r_state       <= DONE;
              r_done        <= 1'b1;
              r_doneAborted <= 1'b0;
              r_doneCount   <= '0;
            end else begin
              r_state  <= RUN;
              r_mValid <= 1'b1;
              r_mLast  <= (cmd_count == COUNT_WIDTH'(1));
            end
          end
        end

        RUN: begin
          // The pending flag never withdraws or alters the presented beat.
          if (abort) begin
            r_abortPending <= 1'b1;
          end
          if (w_beatXfer) begin
            r_cur       <= r_cur + r_stride;
            r_remaining <= w_remainingNext;
            r_sent      <= w_sentNext;
            if (r_mLast) begin
              // Final beat wins over any abort: normal completion.
              r_state       <= DONE;
              r_mValid      <= 1'b0;
              r_mLast       <= 1'b0;
              r_done        <= 1'b1;
              r_doneAborted <= 1'b0;
              r_doneCount   <= w_sentNext;
            end else if (w_abortNow) begin
              r_state       <= DONE;
              r_mValid      <= 1'b0;
              r_mLast       <= 1'b0;
              r_done        <= 1'b1;
              r_doneAborted <= 1'b1;
              r_doneCount   <= w_sentNext;
            end else begin
              r_mLast <= (w_remainingNext == COUNT_WIDTH'(1));
            end
          end
        end

        DONE: begin
          r_state        <= IDLE;
          r_done         <= 1'b0;
          r_doneAborted  <= 1'b0;
          r_abortPending <= 1'b0;
          r_cmdReady     <= 1'b1;
        end

        default: begin
          r_state    <= IDLE;
          r_mValid   <= 1'b0;
          r_mLast    <= 1'b0;
          r_done     <= 1'b0;
          r_cmdReady <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_stream_sequence_source.sv
// ---------------------------------------------------------------------------
// tb_axi_stream_sequence_source
//
// Drives directed and randomized commands into two copies of the sequence
// source (32-bit and 8-bit data) sharing all control inputs. Expected beats
// are computed as start + k*stride, and the expected end of each command
// (normal or aborted, beat count) follows from the transfer and abort
// pattern the bench itself chooses.
// ---------------------------------------------------------------------------
module tb_axi_stream_sequence_source;

  logic        clk;
  logic        reset;
  logic        cmdValid;
  logic [31:0] cmdStart;
  logic [31:0] cmdStride;
  logic [15:0] cmdCount;
  logic        abortIn;
  logic        mReady;

  logic        cmdReady;
  logic [31:0] mData;
  logic        mValid;
  logic        mLast;
  logic        doneOut;
  logic        doneAborted;
  logic [15:0] doneCount;

  logic        cmdReady8;
  logic [7:0]  mData8;
  logic        mValid8;
  logic        mLast8;
  logic        doneOut8;
  logic        doneAborted8;
  logic [15:0] doneCount8;

  int compared;
  int mismatched;

  axi_stream_sequence_source #(.WIDTH(32), .COUNT_WIDTH(16)) u_dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmdValid),
    .cmd_ready    (cmdReady),
    .cmd_start    (cmdStart),
    .cmd_stride   (cmdStride),
    .cmd_count    (cmdCount),
    .abort        (abortIn),
    .m_data       (mData),
    .m_valid      (mValid),
    .m_ready      (mReady),
    .m_last       (mLast),
    .done         (doneOut),
    .done_aborted (doneAborted),
    .done_count   (doneCount)
  );

  axi_stream_sequence_source #(.WIDTH(8), .COUNT_WIDTH(16)) u_dut8 (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmdValid),
    .cmd_ready    (cmdReady8),
    .cmd_start    (cmdStart[7:0]),
    .cmd_stride   (cmdStride[7:0]),
    .cmd_count    (cmdCount),
    .abort        (abortIn),
    .m_data       (mData8),
    .m_valid      (mValid8),
    .m_ready      (mReady),
    .m_last       (mLast8),
    .done         (doneOut8),
    .done_aborted (doneAborted8),
    .done_count   (doneCount8)
  );

  // 100 MHz clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something wedges the stimulus sequence.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Outputs of both instances while idle between commands.
  task automatic checkIdle(input string tag);
    checkOutput({tag, "_cmdReady"}, 64'(cmdReady), 64'd1);
    checkOutput({tag, "_mValid"}, 64'(mValid), 64'd0);
    checkOutput({tag, "_done"}, 64'(doneOut), 64'd0);
    checkOutput({tag, "_cmdReady8"}, 64'(cmdReady8), 64'd1);
    checkOutput({tag, "_mValid8"}, 64'(mValid8), 64'd0);
  endtask

  // Runs one complete command. readyMode: 0 = always ready, 1 = bit pattern
  // (bit k applies to stream cycle k, ready after bit 31), 2 = random.
  // abortCycle selects the stream cycle carrying a one-cycle abort pulse
  // (-1 for none); abortOnAccept raises abort on the accept edge.
  task automatic applyStimulus(input string tag, input logic [31:0] start,
                               input logic [31:0] stride, input int count,
                               input int readyMode, input logic [31:0] pattern,
                               input int abortCycle, input bit abortOnAccept);
    int    cyc;
    int    sent;
    bit    pending;
    bit    ended;
    bit    expAborted;
    bit    ready;
    bit    ab;
    logic [31:0] expData;

    cmdValid  = 1'b1;
    cmdStart  = start;
    cmdStride = stride;
    cmdCount  = 16'(count);
    abortIn   = abortOnAccept;
    mReady    = 1'($urandom_range(0, 1));
    checkOutput({tag, "_acceptReady"}, 64'(cmdReady), 64'd1);
    stepCycle();
    cmdValid  = 1'b0;
    cmdStart  = $urandom;
    cmdStride = $urandom;
    cmdCount  = 16'($urandom);
    abortIn   = 1'b0;

    sent       = 0;
    pending    = 1'b0;
    ended      = (count == 0);
    expAborted = 1'b0;
    cyc        = 0;
    while (!ended && cyc < 2000) begin
      expData = start + stride * 32'(sent);
      checkOutput({tag, "_mValid"}, 64'(mValid), 64'd1);
      checkOutput({tag, "_mData"}, 64'(mData), 64'(expData));
      checkOutput({tag, "_mLast"}, 64'(mLast), 64'(sent == count - 1));
      checkOutput({tag, "_cmdReadyBusy"}, 64'(cmdReady), 64'd0);
      checkOutput({tag, "_doneBusy"}, 64'(doneOut), 64'd0);
      checkOutput({tag, "_mValid8"}, 64'(mValid8), 64'd1);
      checkOutput({tag, "_mData8"}, 64'(mData8), 64'(expData[7:0]));
      checkOutput({tag, "_mLast8"}, 64'(mLast8), 64'(sent == count - 1));

      case (readyMode)
        0:       ready = 1'b1;
        1:       ready = (cyc < 32) ? pattern[cyc] : 1'b1;
        default: ready = ($urandom_range(0, 2) != 0) || (cyc > 500);
      endcase
      ab      = (cyc == abortCycle);
      mReady  = ready;
      abortIn = ab;
      if (ab) pending = 1'b1;
      if (ready) begin
        sent++;
        if (sent == count) begin
          ended      = 1'b1;
          expAborted = 1'b0;
        end else if (pending) begin
          ended      = 1'b1;
          expAborted = 1'b1;
        end
      end
      stepCycle();
      cyc++;
    end
    checkOutput({tag, "_ended"}, 64'(ended), 64'd1);

    // Completion cycle; abort here must have no effect.
    mReady  = 1'($urandom_range(0, 1));
    abortIn = 1'b1;
    checkOutput({tag, "_done"}, 64'(doneOut), 64'd1);
    checkOutput({tag, "_doneCount"}, 64'(doneCount), 64'(sent));
    checkOutput({tag, "_doneAborted"}, 64'(doneAborted), 64'(expAborted));
    checkOutput({tag, "_mValidDone"}, 64'(mValid), 64'd0);
    checkOutput({tag, "_cmdReadyDone"}, 64'(cmdReady), 64'd0);
    checkOutput({tag, "_done8"}, 64'(doneOut8), 64'd1);
    checkOutput({tag, "_doneCount8"}, 64'(doneCount8), 64'(sent));
    checkOutput({tag, "_doneAborted8"}, 64'(doneAborted8), 64'(expAborted));
    stepCycle();
    abortIn = 1'b0;
    checkIdle({tag, "_after"});
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset      = 1'b1;
    cmdValid   = 1'b0;
    cmdStart   = '0;
    cmdStride  = '0;
    cmdCount   = '0;
    abortIn    = 1'b0;
    mReady     = 1'b0;

    // Reset state
    stepCycle();
    stepCycle();
    checkOutput("rst_cmdReady", 64'(cmdReady), 64'd0);
    checkOutput("rst_mValid", 64'(mValid), 64'd0);
    checkOutput("rst_mLast", 64'(mLast), 64'd0);
    checkOutput("rst_mData", 64'(mData), 64'd0);
    checkOutput("rst_done", 64'(doneOut), 64'd0);
    checkOutput("rst_doneAborted", 64'(doneAborted), 64'd0);
    checkOutput("rst_doneCount", 64'(doneCount), 64'd0);
    reset = 1'b0;
    stepCycle();
    checkIdle("rstRelease");

    // Basic sequence at full throughput
    applyStimulus("t1", 32'd5, 32'd3, 4, 0, 32'h0, -1, 1'b0);

    // Stall pattern 1,0,0,1,0,1,1
    applyStimulus("t2", 32'd5, 32'd3, 4, 1, 32'h0000_0069, -1, 1'b0);

    // Modular wrap: 8-bit copy sees FE,FF,00
    applyStimulus("t3", 32'hFFFF_FFFE, 32'd1, 3, 0, 32'h0, -1, 1'b0);

    // Empty command
    applyStimulus("t4", 32'd77, 32'd9, 0, 0, 32'h0, -1, 1'b0);

    // Abort while beat 4 is stalled
    applyStimulus("t5", 32'd100, 32'd7, 10, 1, 32'h0000_0027, 3, 1'b0);

    // Abort coincident with the final beat: normal completion
    applyStimulus("t5b", 32'd1, 32'd1, 3, 0, 32'h0, 2, 1'b0);

    // Abort on the accept edge is ignored
    applyStimulus("t5c", 32'd40, 32'd2, 3, 0, 32'h0, -1, 1'b1);

    // Reset during beat 2
    cmdValid  = 1'b1;
    cmdStart  = 32'd5;
    cmdStride = 32'd3;
    cmdCount  = 16'd5;
    mReady    = 1'b1;
    stepCycle();
    cmdValid = 1'b0;
    checkOutput("t6_beat1", 64'(mData), 64'd5);
    stepCycle();
    checkOutput("t6_beat2", 64'(mData), 64'd8);
    checkOutput("t6_beat2Valid", 64'(mValid), 64'd1);
    reset = 1'b1;
    stepCycle();
    checkOutput("t6_rstValid", 64'(mValid), 64'd0);
    checkOutput("t6_rstDone", 64'(doneOut), 64'd0);
    checkOutput("t6_rstCmdReady", 64'(cmdReady), 64'd0);
    reset = 1'b0;
    stepCycle();
    checkOutput("t6_postDone", 64'(doneOut), 64'd0);
    checkIdle("t6_post");
    applyStimulus("t6_fresh", 32'd5, 32'd3, 4, 0, 32'h0, -1, 1'b0);

    // Randomized commands
    for (int i = 0; i < 16; i++) begin
      int ac;
      ac = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 12)) : -1;
      applyStimulus($sformatf("rnd%0d", i), $urandom, $urandom,
                    int'($urandom_range(0, 9)), 2, 32'h0, ac,
                    1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
